// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with stall/flush handling and MADD/MSUB accumulate parking (optional perf counters via EX_MEM_PERF_CNT_EN)
module ex_mem_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic                ex_whilo,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_whilo,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [1:0]          cnt_o
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]         bubble_cnt_o,
  output logic [31:0]         hold_cnt_o
`endif
);
  localparam int PW = ADDR_W + 2 + 3 * DATA_W;
  logic [PW-1:0] pay_d, pay_q, ex_pay;
  logic [2*DATA_W-1:0] hilo_d, hilo_q;
  logic [1:0] cnt_d, cnt_q;
  logic bubble, hold, adv;
  logic unused_stall;
  assign unused_stall = ^stall;
  assign bubble = stall[EX_IDX] & ~stall[MEM_IDX];
  assign hold   = stall[MEM_IDX];
  assign adv    = ~stall[EX_IDX] & ~stall[MEM_IDX];
  assign ex_pay = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo};
  assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo} = pay_q;
  assign hilo_o = hilo_q;
  assign cnt_o  = cnt_q;
  // next state: flush/bubble insert a NOP, hold keeps, advance takes EX; bubble parks the accumulate
  always_comb begin
    pay_d  = (flush | bubble) ? '0 : adv ? ex_pay : pay_q;
    hilo_d = (flush | adv) ? '0 : bubble ? hilo_i : hilo_q;
    cnt_d  = (flush | adv) ? '0 : bubble ? cnt_i : cnt_q;
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q  <= '0;
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      pay_q  <= pay_d;
      hilo_q <= hilo_d;
      cnt_q  <= cnt_d;
    end
  end
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q, hold_cnt_d, hold_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
  assign hold_cnt_o   = hold_cnt_q;
  // count bubble and hold edges; a flush edge is neither, and flush never clears the counts
  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'b0, bubble & ~flush};
    hold_cnt_d   = hold_cnt_q + {31'b0, hold & ~flush};
  end
  // counter registers, cleared by reset only
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table-driven self-checking bench for ex_mem_reg
module tb_ex_mem_reg;
  logic clk = 0;
  logic rst, flush, ex_wreg, ex_whilo;
  logic [5:0] stall;
  logic [4:0] ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0] cnt_i;
  logic [4:0] mem_wd;
  logic mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_o;
  logic [1:0] cnt_o;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] bubble_cnt_o, hold_cnt_o;
`endif
  int checks = 0, failures = 0;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .hilo_o(hilo_o), .cnt_o(cnt_o)
`ifdef EX_MEM_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o)
`endif
  );

  typedef struct {
    logic r, f;
    logic [5:0] st;
    logic [4:0] wd;
    logic wreg;
    logic [31:0] wdata, hi, lo;
    logic whilo;
    logic [63:0] hilo;
    logic [1:0] cnt;
    logic [4:0] e_wd;
    logic e_wreg;
    logic [31:0] e_wdata, e_hi, e_lo;
    logic e_whilo;
    logic [63:0] e_hilo;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t v[18];

  function automatic vec_t row(logic r, logic f, logic [5:0] st, logic [4:0] wd, logic wreg,
                               logic [31:0] wdata, logic [31:0] hi, logic [31:0] lo, logic whilo,
                               logic [63:0] hilo, logic [1:0] cnt, logic [4:0] e_wd, logic e_wreg,
                               logic [31:0] e_wdata, logic [31:0] e_hi, logic [31:0] e_lo,
                               logic e_whilo, logic [63:0] e_hilo, logic [1:0] e_cnt);
    vec_t x;
    x.r = r; x.f = f; x.st = st; x.wd = wd; x.wreg = wreg; x.wdata = wdata; x.hi = hi;
    x.lo = lo; x.whilo = whilo; x.hilo = hilo; x.cnt = cnt;
    x.e_wd = e_wd; x.e_wreg = e_wreg; x.e_wdata = e_wdata; x.e_hi = e_hi; x.e_lo = e_lo;
    x.e_whilo = e_whilo; x.e_hilo = e_hilo; x.e_cnt = e_cnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [31:0] hi, input logic [31:0] lo,
                         input logic whilo, input logic [63:0] hilo, input logic [1:0] cnt);
    chk({tag, ".mem_wd"}, 64'(mem_wd), 64'(wd));
    chk({tag, ".mem_wreg"}, 64'(mem_wreg), 64'(wreg));
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(wdata));
    chk({tag, ".mem_hi"}, 64'(mem_hi), 64'(hi));
    chk({tag, ".mem_lo"}, 64'(mem_lo), 64'(lo));
    chk({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(whilo));
    chk({tag, ".hilo_o"}, hilo_o, hilo);
    chk({tag, ".cnt_o"}, 64'(cnt_o), 64'(cnt));
  endtask

  task automatic drive(input vec_t x);
    rst = x.r; flush = x.f; stall = x.st; ex_wd = x.wd; ex_wreg = x.wreg; ex_wdata = x.wdata;
    ex_hi = x.hi; ex_lo = x.lo; ex_whilo = x.whilo; hilo_i = x.hilo; cnt_i = x.cnt;
  endtask

  task automatic step(input logic r, input logic f, input logic [5:0] st);
    @(negedge clk);
    rst = r; flush = f; stall = st;
    ex_wdata = $urandom; hilo_i = {$urandom, $urandom}; cnt_i = 2'($urandom);
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = row(0,0,6'b000000, 5,1,32'h12345678,32'hA,32'hB,1,64'h0,0,
                5,1,32'h12345678,32'hA,32'hB,1,64'h0,0);
    v[1]  = row(0,0,6'b001111, 7,1,32'h55,1,2,1,64'h0000_0001_0000_0002,1,
                0,0,0,0,0,0,64'h0000_0001_0000_0002,1);
    v[2]  = row(0,0,6'b000000, 7,1,32'h55,1,2,0,64'h99,2, 7,1,32'h55,1,2,0,64'h0,0);
    v[3]  = row(0,0,6'b000000, 3,0,32'hDEAD,0,0,0,64'h0,0, 3,0,32'hDEAD,0,0,0,64'h0,0);
    v[4]  = row(0,0,6'b011111, 9,1,32'h1111,1,1,1,64'h5,3, 3,0,32'hDEAD,0,0,0,64'h0,0);
    v[5]  = row(0,0,6'b011111, 10,1,32'h2222,2,2,1,64'h6,2, 3,0,32'hDEAD,0,0,0,64'h0,0);
    v[6]  = row(0,0,6'b011111, 11,1,32'h3333,3,3,1,64'h7,1, 3,0,32'hDEAD,0,0,0,64'h0,0);
    v[7]  = row(0,0,6'b010000, 1,1,32'h77,5,6,1,64'h8,1, 3,0,32'hDEAD,0,0,0,64'h0,0);
    v[8]  = row(0,1,6'b001111, 2,1,32'h88,5,6,1,64'hABCD,2, 0,0,0,0,0,0,64'h0,0);
    v[9]  = row(0,0,6'b001000, 4,1,32'h99,7,8,1,64'hFFFF_FFFF_0000_0001,3,
                0,0,0,0,0,0,64'hFFFF_FFFF_0000_0001,3);
    v[10] = row(0,0,6'b011000, 6,1,32'hAA,7,8,1,64'h5,1,
                0,0,0,0,0,0,64'hFFFF_FFFF_0000_0001,3);
    v[11] = row(0,0,6'b100111, 31,1,ONES,ONES,0,1,64'h7,2, 31,1,ONES,ONES,0,1,64'h0,0);
    v[12] = row(0,0,6'b001000, 8,1,32'hBB,1,1,1,64'h1234,1, 0,0,0,0,0,0,64'h1234,1);
    v[13] = row(1,0,6'b001000, 8,1,32'hBB,1,1,1,64'h1234,1, 0,0,0,0,0,0,64'h0,0);
    v[14] = row(0,0,6'b011000, 8,1,32'hBB,1,1,1,64'h1234,1, 0,0,0,0,0,0,64'h0,0);
    v[15] = row(0,0,6'b000000, 2,1,32'hCC,3,4,1,64'h0,0, 2,1,32'hCC,3,4,1,64'h0,0);
    v[16] = row(0,1,6'b011111, 9,1,32'hDD,5,5,1,64'h3,3, 0,0,0,0,0,0,64'h0,0);
    v[17] = row(0,0,6'b000000, 0,0,32'h0,0,0,0,64'h0,0, 0,0,32'h0,0,0,0,64'h0,0);

    // reset with everything high, then outputs stay zero until the next edge
    @(negedge clk);
    rst = 1; flush = 0; stall = 6'b000000;
    ex_wd = 5'h1F; ex_wreg = 1; ex_wdata = ONES; ex_hi = ONES; ex_lo = ONES; ex_whilo = 1;
    hilo_i = {ONES, ONES}; cnt_i = 2'b11;
    @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 64'h0, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk_all("post_reset", 0, 0, 0, 0, 0, 0, 64'h0, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(v[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), v[i].e_wd, v[i].e_wreg, v[i].e_wdata, v[i].e_hi,
              v[i].e_lo, v[i].e_whilo, v[i].e_hilo, v[i].e_cnt);
    end

`ifdef EX_MEM_PERF_CNT_EN
    step(1, 0, 6'b000000);
    chk("perf.reset_bubble", 64'(bubble_cnt_o), 64'd0);
    chk("perf.reset_hold", 64'(hold_cnt_o), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 6'b011111);
    chk("perf.hold3", 64'(hold_cnt_o), 64'd3);
    chk("perf.bubble0", 64'(bubble_cnt_o), 64'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 6'b001111);
    step(0, 1, 6'b001111);
    chk("perf.after_flush", 64'(bubble_cnt_o), 64'd4);
    step(0, 0, 6'b001111);
    chk("perf.bubble5", 64'(bubble_cnt_o), 64'd5);
    chk("perf.hold_kept", 64'(hold_cnt_o), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
